boc_prn_gen: RTL and testbench
==============================

# boc_prn_gen

Local replica code generator for the B1 acquisition/tracking correlators. It produces a one-bit BOC(1,1)-modulated Gold-code sample every clock, together with integration-window start/end strobes, and drives the correlator accumulator's `rx_loc_boc`, `rx_prn_sop` and `rx_prn_eop` inputs directly. Code rate is set by a half-chip NCO. Initial code phase is set by a seek phase that fast-forwards the LFSRs before output starts.

## Interface
- `CODE_LEN`, 2046: chips per code period (legal range 2..2047; the 2047-chip Gold sequence is truncated).
- `NCO_WIDTH`, 32: half-chip NCO accumulator width.
- `PRN_PHS_WIDTH`, 11: width of the code-phase and chip-index fields.
- `rx_clk` in 1: sole clock.
- `rx_rst` in 1: asynchronous, active-high reset.
- `rx_start` in 1: one-cycle pulse; captures configuration and starts seek.
- `rx_stop` in 1: one-cycle pulse; returns to IDLE.
- `rx_code_fcw` in NCO_WIDTH: half-chip frequency control word, captured at start.
- `rx_prn_phs` in PRN_PHS_WIDTH: initial chip index, 0..CODE_LEN-1, captured at start.
- `rx_g2_tap_a`, `rx_g2_tap_b` in 4 each: G2 phase-select stage indices 1..11, captured at start.
- `tx_loc_boc` in/out: out 1: local replica sample; 1 means +1 (correlator adds).
- `tx_prn_sop` out 1: first sample of an integration window.
- `tx_prn_eop` out 1: last sample of an integration window.
- `tx_busy` out 1: high in SEEK or RUN.
- `tx_err` out 1: one-cycle pulse when a start request carries illegal configuration.
- `tx_chip_idx` out PRN_PHS_WIDTH: code chip index of the current sample.

## Operation
- **LFSRs, 11 stages each, both initialised to 01010101010 (stage 1..11).**
  - G1 polynomial: 1+x+x^7+x^8+x^9+x^10+x^11.
  - G2 polynomial: 1+x+x^2+x^3+x^4+x^5+x^8+x^9+x^11.
  - Chip bit: p = G1[11] ^ G2[tap_a] ^ G2[tap_b].
- **Chip advance:** both LFSRs shift once and chip index increments. When the index reaches CODE_LEN-1, the next advance reloads both LFSRs to the initial state and sets the index to 0. This is the truncation rule.
- **Subcarrier:** s = 0 in the first half-chip, 1 in the second. `tx_loc_boc` = p ^ s.
- **NCO:** each RUN cycle, acc <= acc + fcw (mod 2^NCO_WIDTH). A carry ends the current half-chip. A carry out of the second half-chip advances the chip.
- **FSM:**
  - IDLE: outputs low. On `rx_start`, validate the configuration. If phs ≥ CODE_LEN, either tap is outside 1..11, or tap_a = tap_b, pulse `tx_err` and stay IDLE. Otherwise load the registers, reset the LFSRs, index, acc and s, and go to SEEK.
  - SEEK: one chip advance per cycle, without output, until index = phs, then go to RUN. If phs = 0, SEEK lasts exactly one cycle with no advance.
  - RUN: emit one sample per cycle.
  - From any state, `rx_start` restarts (IDLE entry then the start sequence in the same cycle) and `rx_stop` goes to IDLE. If both arrive together, `rx_stop` wins.
- **Integration window:**
  - Length is 2*CODE_LEN half-chips, counted from RUN entry by a window half-chip counter independent of the chip index.
  - `tx_prn_sop` is high on the first cycle of window half-chip 0.
  - `tx_prn_eop` is high on the cycle whose half-chip is window half-chip 2*CODE_LEN-1 and whose NCO add carries.
  - The window counter wraps to 0 on that carry, so windows are back-to-back with no gap.
- **Reset:** all state and outputs are 0, the FSM is in IDLE, and the LFSRs are at the initial state. Reset mid-RUN aborts immediately, with no trailing eop.

## Timing
- All outputs are registered.
- `rx_start` at cycle t gives SEEK from t+1.
- The first RUN sample, with `tx_prn_sop`=1, appears at cycle t+2+phs. For phs=0 that is t+2.
- Config inputs are sampled only on the `rx_start` cycle.
- `tx_err` appears at t+1.
- `tx_busy` drops the cycle after `rx_stop`.
- With fcw = 2^(NCO_WIDTH-1), each half-chip lasts 2 cycles and a window lasts 4*CODE_LEN cycles.
- For fcw = 0, no carry occurs. The output holds, and neither sop nor eop repeats.

## Test plan
- **Basic rate:** reset, start with taps (1,3), phs=0, fcw=2^31 → sop at t+2, then every 8184 cycles; eop on the cycle before each subsequent sop. Each chip value is held 4 cycles, with `tx_loc_boc` inverting after 2 cycles. Chip sequence matches the bit-accurate model.
- **Seek:** start with phs=5 → first sample at t+7 with `tx_chip_idx`=5, and sample values equal to chips 5.. of the phs=0 run. `tx_chip_idx` wraps 2045→0 with the LFSR reloaded, so chip 0 matches the phs=0 run's first chip.
- **Illegal config:** phs=2046, or tap_a=12, or tap_a=tap_b → `tx_err` pulse at t+1, `tx_busy` stays 0, and no sop.
- **Restart and stop:**
  - `rx_start` mid-RUN → the sequence restarts with new config and a fresh sop, with no eop for the aborted window.
  - `rx_start` and `rx_stop` in the same cycle → IDLE.
- **Async reset:** assert `rx_rst` between clock edges mid-window → all outputs go to 0 immediately. After release and a new start, output is identical to the first run.
- **fcw=2^30:** each half-chip lasts 4 cycles and the window is 16368 cycles. sop and eop never coincide.

Source files
------------

// File: rtl/boc_prn_gen_if.sv
// Control, configuration and replica-sample bundle between a correlator
// front end (master) and the boc_prn_gen local code generator (slave).
interface boc_prn_gen_if #(
  parameter int NCO_WIDTH     = 32,
  parameter int PRN_PHS_WIDTH = 11
);
  logic                     rx_start;
  logic                     rx_stop;
  logic [NCO_WIDTH-1:0]     rx_code_fcw;
  logic [PRN_PHS_WIDTH-1:0] rx_prn_phs;
  logic [3:0]               rx_g2_tap_a;
  logic [3:0]               rx_g2_tap_b;
  logic                     tx_loc_boc;
  logic                     tx_prn_sop;
  logic                     tx_prn_eop;
  logic                     tx_busy;
  logic                     tx_err;
  logic [PRN_PHS_WIDTH-1:0] tx_chip_idx;

  modport master (
    output rx_start, rx_stop, rx_code_fcw, rx_prn_phs, rx_g2_tap_a, rx_g2_tap_b,
    input  tx_loc_boc, tx_prn_sop, tx_prn_eop, tx_busy, tx_err, tx_chip_idx
  );

  modport slave (
    input  rx_start, rx_stop, rx_code_fcw, rx_prn_phs, rx_g2_tap_a, rx_g2_tap_b,
    output tx_loc_boc, tx_prn_sop, tx_prn_eop, tx_busy, tx_err, tx_chip_idx
  );
endinterface

// File: rtl/boc_prn_gen.sv
// BOC(1,1) Gold-code local replica generator with half-chip NCO, seek-to-phase
// start-up and back-to-back integration-window sop/eop strobes.
module boc_prn_gen #(
  parameter int CODE_LEN      = 2046,
  parameter int NCO_WIDTH     = 32,
  parameter int PRN_PHS_WIDTH = 11
) (
  input  logic         rx_clk,
  input  logic         rx_rst,
  boc_prn_gen_if.slave bus
);
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEEK = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  localparam int                       WIN_W     = $clog2(2 * CODE_LEN);
  localparam logic [WIN_W-1:0]         WIN_LAST  = WIN_W'(2 * CODE_LEN - 1);
  localparam logic [PRN_PHS_WIDTH-1:0] IDX_LAST  = PRN_PHS_WIDTH'(CODE_LEN - 1);
  localparam logic [11:1]              LFSR_INIT = 11'b01010101010;

  logic [1:0]               state_reg, state_next;
  logic [NCO_WIDTH-1:0]     fcw_reg, fcw_next;
  logic [PRN_PHS_WIDTH-1:0] phs_reg, phs_next;
  logic [3:0]               tap_a_reg, tap_a_next;
  logic [3:0]               tap_b_reg, tap_b_next;
  logic [11:1]              g1_reg, g1_next;
  logic [11:1]              g2_reg, g2_next;
  logic [PRN_PHS_WIDTH-1:0] idx_reg, idx_next;
  logic                     half_reg, half_next;
  logic [WIN_W-1:0]         win_reg, win_next;
  logic [NCO_WIDTH-1:0]     acc_reg, acc_next;
  logic                     carry_reg, carry_next;
  logic                     boc_reg, boc_next;
  logic                     sop_reg, sop_next;
  logic                     eop_reg, eop_next;
  logic                     busy_reg, busy_next;
  logic                     err_reg, err_next;
  logic [PRN_PHS_WIDTH-1:0] chip_idx_reg, chip_idx_next;

  logic                     g1_fb, g2_fb;
  logic [11:1]              g1_shift, g2_shift;
  logic [11:1]              g1_adv, g2_adv;
  logic [PRN_PHS_WIDTH-1:0] idx_adv;
  logic                     cfg_bad;
  logic [NCO_WIDTH:0]       acc_sum;
  logic                     run_out;

  function automatic logic chip_bit(input logic [11:1] g1, input logic [11:1] g2,
                                    input logic [3:0] ta, input logic [3:0] tb);
    logic [15:0] g2_ext;
    g2_ext = {4'b0000, g2, 1'b0};
    return g1[11] ^ g2_ext[ta] ^ g2_ext[tb];
  endfunction

  assign g1_fb = g1_reg[1] ^ g1_reg[7] ^ g1_reg[8] ^ g1_reg[9] ^ g1_reg[10] ^ g1_reg[11];
  assign g2_fb = g2_reg[1] ^ g2_reg[2] ^ g2_reg[3] ^ g2_reg[4] ^ g2_reg[5]
               ^ g2_reg[8] ^ g2_reg[9] ^ g2_reg[11];

  assign g1_shift[1] = g1_fb;
  assign g2_shift[1] = g2_fb;
  for (genvar gi = 2; gi <= 11; gi++) begin : g_shift
    assign g1_shift[gi] = g1_reg[gi-1];
    assign g2_shift[gi] = g2_reg[gi-1];
  end

  // Truncated code: the chip after the last one restarts from the seed state.
  assign g1_adv  = (idx_reg == IDX_LAST) ? LFSR_INIT : g1_shift;
  assign g2_adv  = (idx_reg == IDX_LAST) ? LFSR_INIT : g2_shift;
  assign idx_adv = (idx_reg == IDX_LAST) ? '0 : idx_reg + PRN_PHS_WIDTH'(1);

  assign cfg_bad = (32'(bus.rx_prn_phs) >= CODE_LEN)
                || (bus.rx_g2_tap_a == 4'd0) || (bus.rx_g2_tap_a > 4'd11)
                || (bus.rx_g2_tap_b == 4'd0) || (bus.rx_g2_tap_b > 4'd11)
                || (bus.rx_g2_tap_a == bus.rx_g2_tap_b);

  // acc_reg already holds the post-add value of the sample on the output and
  // carry_reg its carry, so eop can be registered one adder deep.
  always_comb begin
    state_next = state_reg;
    fcw_next   = fcw_reg;
    phs_next   = phs_reg;
    tap_a_next = tap_a_reg;
    tap_b_next = tap_b_reg;
    g1_next    = g1_reg;
    g2_next    = g2_reg;
    idx_next   = idx_reg;
    half_next  = half_reg;
    win_next   = win_reg;
    acc_next   = acc_reg;
    carry_next = carry_reg;
    sop_next   = 1'b0;
    eop_next   = 1'b0;
    acc_sum    = {1'b0, acc_reg} + {1'b0, fcw_reg};
    err_next   = bus.rx_start && !bus.rx_stop && cfg_bad;

    case (state_reg)
      ST_SEEK: begin
        if (idx_reg == phs_reg) begin
          state_next = ST_RUN;
          sop_next   = 1'b1;
          acc_next   = fcw_reg;
          carry_next = 1'b0;
        end else begin
          g1_next  = g1_adv;
          g2_next  = g2_adv;
          idx_next = idx_adv;
        end
      end
      ST_RUN: begin
        if (carry_reg) begin
          half_next = ~half_reg;
          win_next  = (win_reg == WIN_LAST) ? '0 : win_reg + WIN_W'(1);
          sop_next  = (win_reg == WIN_LAST);
          if (half_reg) begin
            g1_next  = g1_adv;
            g2_next  = g2_adv;
            idx_next = idx_adv;
          end
        end
        {carry_next, acc_next} = acc_sum;
        eop_next = (win_next == WIN_LAST) && acc_sum[NCO_WIDTH];
      end
      default: ;
    endcase

    if (bus.rx_stop) begin
      state_next = ST_IDLE;
      sop_next   = 1'b0;
      eop_next   = 1'b0;
    end else if (bus.rx_start) begin
      state_next = ST_IDLE;
      sop_next   = 1'b0;
      eop_next   = 1'b0;
      if (!cfg_bad) begin
        state_next = ST_SEEK;
        fcw_next   = bus.rx_code_fcw;
        phs_next   = bus.rx_prn_phs;
        tap_a_next = bus.rx_g2_tap_a;
        tap_b_next = bus.rx_g2_tap_b;
        g1_next    = LFSR_INIT;
        g2_next    = LFSR_INIT;
        idx_next   = '0;
        half_next  = 1'b0;
        win_next   = '0;
        acc_next   = '0;
        carry_next = 1'b0;
      end
    end

    run_out       = (state_next == ST_RUN);
    boc_next      = run_out && (chip_bit(g1_next, g2_next, tap_a_next, tap_b_next) ^ half_next);
    chip_idx_next = run_out ? idx_next : '0;
    busy_next     = (state_next != ST_IDLE);
  end

  always_ff @(posedge rx_clk or posedge rx_rst) begin
    if (rx_rst) begin
      state_reg    <= ST_IDLE;
      fcw_reg      <= '0;
      phs_reg      <= '0;
      tap_a_reg    <= '0;
      tap_b_reg    <= '0;
      g1_reg       <= LFSR_INIT;
      g2_reg       <= LFSR_INIT;
      idx_reg      <= '0;
      half_reg     <= 1'b0;
      win_reg      <= '0;
      acc_reg      <= '0;
      carry_reg    <= 1'b0;
      boc_reg      <= 1'b0;
      sop_reg      <= 1'b0;
      eop_reg      <= 1'b0;
      busy_reg     <= 1'b0;
      err_reg      <= 1'b0;
      chip_idx_reg <= '0;
    end else begin
      state_reg    <= state_next;
      fcw_reg      <= fcw_next;
      phs_reg      <= phs_next;
      tap_a_reg    <= tap_a_next;
      tap_b_reg    <= tap_b_next;
      g1_reg       <= g1_next;
      g2_reg       <= g2_next;
      idx_reg      <= idx_next;
      half_reg     <= half_next;
      win_reg      <= win_next;
      acc_reg      <= acc_next;
      carry_reg    <= carry_next;
      boc_reg      <= boc_next;
      sop_reg      <= sop_next;
      eop_reg      <= eop_next;
      busy_reg     <= busy_next;
      err_reg      <= err_next;
      chip_idx_reg <= chip_idx_next;
    end
  end

  assign bus.tx_loc_boc  = boc_reg;
  assign bus.tx_prn_sop  = sop_reg;
  assign bus.tx_prn_eop  = eop_reg;
  assign bus.tx_busy     = busy_reg;
  assign bus.tx_err      = err_reg;
  assign bus.tx_chip_idx = chip_idx_reg;
endmodule

// File: tb/tb_boc_prn_gen.sv
// Scoreboard bench for boc_prn_gen: a half-chip-count reference model queues the
// expected output of every cycle; a negedge monitor pops and compares.
module tb_boc_prn_gen;
  localparam int CODE_LEN  = 2046;
  localparam int NCO_WIDTH = 32;
  localparam int PW        = 11;

  typedef struct packed {
    logic          boc;
    logic          sop;
    logic          eop;
    logic          busy;
    logic          err;
    logic [PW-1:0] idx;
  } smp_t;

  logic rx_clk = 1'b0;
  logic rx_rst = 1'b1;

  boc_prn_gen_if #(.NCO_WIDTH(NCO_WIDTH), .PRN_PHS_WIDTH(PW)) bus ();

  boc_prn_gen #(.CODE_LEN(CODE_LEN), .NCO_WIDTH(NCO_WIDTH), .PRN_PHS_WIDTH(PW)) dut (
    .rx_clk (rx_clk),
    .rx_rst (rx_rst),
    .bus    (bus)
  );

  always #5 rx_clk = ~rx_clk;

  int    n_tests = 0;
  int    n_fail  = 0;
  string cur_tag = "reset";
  smp_t  exp_q[$];

  // Reference model: mode 0 idle, 1 seek, 2 run; m_h counts half-chips since RUN entry.
  int          m_mode     = 0;
  int          m_seek_cnt = 0;
  int          m_h        = 0;
  int          m_phs      = 0;
  logic [31:0] m_acc      = '0;
  logic [31:0] m_fcw      = '0;
  bit          m_newhalf  = 1'b0;
  bit          m_err      = 1'b0;
  bit          chips [CODE_LEN];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic smp_t dut_sample();
    smp_t s;
    s.boc  = bus.tx_loc_boc;
    s.sop  = bus.tx_prn_sop;
    s.eop  = bus.tx_prn_eop;
    s.busy = bus.tx_busy;
    s.err  = bus.tx_err;
    s.idx  = bus.tx_chip_idx;
    return s;
  endfunction

  function automatic bit cfg_bad(input int phs, input int ta, input int tb);
    return (phs >= CODE_LEN) || (ta < 1) || (ta > 11) || (tb < 1) || (tb > 11) || (ta == tb);
  endfunction

  function automatic void build_chips(input int ta, input int tb);
    bit g1 [1:11];
    bit g2 [1:11];
    bit f1, f2;
    for (int k = 1; k <= 11; k++) begin
      g1[k] = (k % 2 == 0);
      g2[k] = (k % 2 == 0);
    end
    for (int i = 0; i < CODE_LEN; i++) begin
      chips[i] = g1[11] ^ g2[ta] ^ g2[tb];
      f1 = g1[1] ^ g1[7] ^ g1[8] ^ g1[9] ^ g1[10] ^ g1[11];
      f2 = g2[1] ^ g2[2] ^ g2[3] ^ g2[4] ^ g2[5] ^ g2[8] ^ g2[9] ^ g2[11];
      for (int k = 11; k >= 2; k--) begin
        g1[k] = g1[k-1];
        g2[k] = g2[k-1];
      end
      g1[1] = f1;
      g2[1] = f2;
    end
  endfunction

  function automatic smp_t model_expect();
    smp_t        e;
    logic [32:0] sum;
    int          idx, win, half;
    e      = '0;
    e.err  = m_err;
    e.busy = (m_mode != 0);
    if (m_mode == 2) begin
      sum   = {1'b0, m_acc} + {1'b0, m_fcw};
      idx   = (m_phs + m_h / 2) % CODE_LEN;
      half  = m_h % 2;
      win   = m_h % (2 * CODE_LEN);
      e.idx = PW'(idx);
      e.boc = chips[idx] ^ (half == 1);
      e.sop = (win == 0) && m_newhalf;
      e.eop = (win == 2 * CODE_LEN - 1) && sum[32];
    end
    return e;
  endfunction

  function automatic void model_advance(input bit start, input bit stop, input logic [31:0] fcw,
                                        input int phs, input int ta, input int tb);
    logic [32:0] sum;
    m_err = start && !stop && cfg_bad(phs, ta, tb);
    if (stop) begin
      m_mode = 0;
    end else if (start) begin
      if (cfg_bad(phs, ta, tb)) begin
        m_mode = 0;
      end else begin
        m_mode     = 1;
        m_seek_cnt = phs + 1;
        m_phs      = phs;
        m_fcw      = fcw;
        build_chips(ta, tb);
      end
    end else if (m_mode == 1) begin
      m_seek_cnt--;
      if (m_seek_cnt == 0) begin
        m_mode    = 2;
        m_h       = 0;
        m_acc     = '0;
        m_newhalf = 1'b1;
      end
    end else if (m_mode == 2) begin
      sum = {1'b0, m_acc} + {1'b0, m_fcw};
      if (sum[32]) begin
        m_h++;
        m_newhalf = 1'b1;
      end else begin
        m_newhalf = 1'b0;
      end
      m_acc = sum[31:0];
    end
  endfunction

  // One clock cycle: queue this cycle's expected outputs, then drive inputs for the next edge.
  task automatic step(input bit start, input bit stop, input logic [31:0] fcw,
                      input int phs, input int ta, input int tb);
    @(posedge rx_clk);
    #1;
    exp_q.push_back(model_expect());
    bus.rx_start = start;
    bus.rx_stop  = stop;
    if (start || stop) begin
      bus.rx_code_fcw = fcw;
      bus.rx_prn_phs  = PW'(phs);
      bus.rx_g2_tap_a = 4'(ta);
      bus.rx_g2_tap_b = 4'(tb);
    end else begin
      bus.rx_code_fcw = $urandom;
      bus.rx_prn_phs  = PW'($urandom);
      bus.rx_g2_tap_a = 4'($urandom);
      bus.rx_g2_tap_b = 4'($urandom);
    end
    model_advance(start, stop, fcw, phs, ta, tb);
  endtask

  task automatic run_cycles(input int n);
    repeat (n) step(1'b0, 1'b0, '0, 0, 0, 0);
  endtask

  task automatic do_start(input string tag, input logic [31:0] fcw, input int phs,
                          input int ta, input int tb);
    cur_tag = tag;
    $display("[TB] %s: start fcw=%08h phs=%0d taps=(%0d,%0d)", tag, fcw, phs, ta, tb);
    step(1'b1, 1'b0, fcw, phs, ta, tb);
  endtask

  task automatic do_stop(input string tag);
    cur_tag = tag;
    $display("[TB] %s: stop", tag);
    step(1'b0, 1'b1, '0, 0, 1, 3);
  endtask

  always @(negedge rx_clk) begin
    if (exp_q.size() != 0)
      check_val(cur_tag, 32'(dut_sample()), 32'(exp_q.pop_front()));
  end

  initial begin
    bus.rx_start    = 1'b0;
    bus.rx_stop     = 1'b0;
    bus.rx_code_fcw = '0;
    bus.rx_prn_phs  = '0;
    bus.rx_g2_tap_a = '0;
    bus.rx_g2_tap_b = '0;
    repeat (3) @(posedge rx_clk);
    #1;
    check_val("reset_state", 32'(dut_sample()), 32'(0));
    rx_rst = 1'b0;
    $display("[TB] reset released");

    // Two full windows at 2 cycles per half-chip, including the 2045->0 chip wrap.
    do_start("basic", 32'h8000_0000, 0, 1, 3);
    run_cycles(2 * 4 * CODE_LEN + 8);
    do_stop("stop");
    run_cycles(3);

    do_start("seek5", 32'h8000_0000, 5, 1, 3);
    run_cycles(200);
    do_start("seek_wrap", 32'h8000_0000, 2040, 1, 3);
    run_cycles(2041 + 60);

    do_start("restart", 32'h8000_0000, 3, 2, 6);
    run_cycles(100);
    do_start("illegal_in_run", 32'h8000_0000, 0, 4, 4);
    run_cycles(4);
    do_start("restart2", 32'h4000_0000, 7, 1, 11);
    run_cycles(60);
    cur_tag = "start_stop";
    $display("[TB] start_stop: start and stop together");
    step(1'b1, 1'b1, 32'h8000_0000, 0, 1, 3);
    run_cycles(5);

    do_start("bad_phs", 32'h8000_0000, 2046, 1, 3);
    run_cycles(5);
    do_start("bad_tap12", 32'h8000_0000, 0, 12, 3);
    run_cycles(5);
    do_start("bad_tap_eq", 32'h8000_0000, 0, 5, 5);
    run_cycles(5);
    do_start("bad_tap0", 32'h8000_0000, 0, 1, 0);
    run_cycles(5);

    do_start("fcw_zero", 32'h0000_0000, 9, 1, 3);
    run_cycles(30);

    do_start("pre_async", 32'h8000_0000, 0, 1, 3);
    run_cycles(300);
    @(posedge rx_clk);
    #3;
    rx_rst = 1'b1;
    #1;
    cur_tag = "async_rst";
    $display("[TB] async_rst: reset asserted mid-window");
    check_val("async_rst", 32'(dut_sample()), 32'(0));
    m_mode = 0;
    m_err  = 1'b0;
    repeat (2) @(posedge rx_clk);
    #1;
    rx_rst = 1'b0;
    do_start("post_async", 32'h8000_0000, 0, 1, 3);
    run_cycles(300);

    do_start("fcw_quarter", 32'h4000_0000, 0, 1, 3);
    run_cycles(16 * CODE_LEN + 40);
    do_stop("final_stop");
    run_cycles(3);

    @(negedge rx_clk);
    #1;
    check_val("sb_drain", 32'(exp_q.size()), 32'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
